// File: rtl/debug_bridge.sv
// debug_bridge: host-side debug initiator on the shared memory bus.
//
// A host drives byte commands over the UART stream:
//   'R' a3 a2 a1 a0          -> d3 d2 d1 d0   (bus read, MSB first)
//   'W' a3 a2 a1 a0 d3..d0   -> 'K'           (bus write, MSB first)
//   anything else            -> '?'
// Address and data pass through unmodified; the bus ignores address[1:0].
//
// Optional feature (macro DEBUG_BRIDGE_TIMEOUT_EN): a bus request that sees
// no ready_in for TIMEOUT_CYCLES cycles is abandoned and answered with 'E'.
// The default build waits for ready_in indefinitely.
//
// Ports:
//   clk, reset          sole clock; synchronous active-high reset
//   rx_valid_in/data_in received byte strobe (no backpressure)
//   tx_valid_out/ready_in/data_out  response byte stream
//   address_out, read_out, write_out, write_mask_out, write_value_out
//                       bus request, held constant while in BUS
//   read_value_in, ready_in  bus completion and read data
//
// Handshakes: the tx side is strict valid/ready -- a byte transfers on a
// cycle where tx_valid_out && tx_ready_in; tx_data_out is stable while
// tx_valid_out && !tx_ready_in. The bus side holds the request until the
// cycle ready_in=1, which completes it.
//
// The FSM state register state_q is the observable debug point for checkers.
module debug_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid_in,
  input  logic [7:0]  rx_data_in,
  output logic        tx_valid_out,
  input  logic        tx_ready_in,
  output logic [7:0]  tx_data_out,
  output logic [31:0] address_out,
  output logic        read_out,
  output logic        write_out,
  output logic [3:0]  write_mask_out,
  output logic [31:0] write_value_out,
  input  logic [31:0] read_value_in,
  input  logic        ready_in
);

  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] RSP_OK    = 8'h4B;
  localparam logic [7:0] RSP_BAD   = 8'h3F;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("debug_bridge: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_BUS,
    S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        is_write_q, is_write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  // Response bytes leave from the top byte; the register shifts left per byte.
  logic [31:0] resp_q, resp_d;
  // Set when the response is a single status byte rather than 4 data bytes.
  logic        single_q, single_d;

`ifdef DEBUG_BRIDGE_TIMEOUT_EN
  localparam logic [7:0] RSP_TIMEOUT = 8'h45;
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q;
  logic             tmo_hit;

  // Counts BUS cycles; zero in the first BUS cycle because it clears elsewhere.
  always_ff @(posedge clk) begin
    if (reset || state_q != S_BUS) tmo_q <= '0;
    else                           tmo_q <= tmo_q + TMO_W'(1);
  end
  assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 2'd0;
      is_write_q <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      resp_q     <= 32'd0;
      single_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_write_q <= is_write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      resp_q     <= resp_d;
      single_q   <= single_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_write_d = is_write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    resp_d     = resp_q;
    single_d   = single_q;
    case (state_q)
      S_IDLE: begin
        if (rx_valid_in) begin
          if (rx_data_in == CMD_READ || rx_data_in == CMD_WRITE) begin
            is_write_d = (rx_data_in == CMD_WRITE);
            cnt_d      = 2'd0;
            state_d    = S_ADDR;
          end else begin
            resp_d   = {RSP_BAD, 24'd0};
            single_d = 1'b1;
            state_d  = S_RESP;
          end
        end
      end
      S_ADDR: begin
        if (rx_valid_in) begin
          addr_d = {addr_q[23:0], rx_data_in};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = is_write_q ? S_DATA : S_BUS;
        end
      end
      S_DATA: begin
        if (rx_valid_in) begin
          wdata_d = {wdata_q[23:0], rx_data_in};
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = S_BUS;
        end
      end
      S_BUS: begin
        // ready_in takes priority, so a completion on the timeout cycle wins.
        if (ready_in) begin
          resp_d   = is_write_q ? {RSP_OK, 24'd0} : read_value_in;
          single_d = is_write_q;
          cnt_d    = 2'd0;
          state_d  = S_RESP;
        end
`ifdef DEBUG_BRIDGE_TIMEOUT_EN
        else if (tmo_hit) begin
          resp_d   = {RSP_TIMEOUT, 24'd0};
          single_d = 1'b1;
          cnt_d    = 2'd0;
          state_d  = S_RESP;
        end
`endif
      end
      S_RESP: begin
        if (tx_ready_in) begin
          if (single_q || cnt_q == 2'd3) begin
            cnt_d   = 2'd0;
            state_d = S_IDLE;
          end else begin
            resp_d = {resp_q[23:0], 8'd0};
            cnt_d  = cnt_q + 2'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign read_out        = (state_q == S_BUS) && !is_write_q;
  assign write_out       = (state_q == S_BUS) && is_write_q;
  assign write_mask_out  = write_out ? 4'b1111 : 4'b0000;
  assign address_out     = addr_q;
  assign write_value_out = wdata_q;
  assign tx_valid_out    = (state_q == S_RESP);
  assign tx_data_out     = (state_q == S_RESP) ? resp_q[31:24] : 8'd0;

endmodule

// File: tb/tb_debug_bridge.sv
// Directed bench for debug_bridge. Inputs change 1 ns after the rising
// edge; outputs are sampled on the falling edge. Response bytes are checked
// against an expected queue by a monitor that sees every tx handshake.
// Build with +define+DEBUG_BRIDGE_TIMEOUT_EN to add the timeout case.
module tb_debug_bridge;

  logic        clk;
  logic        reset;
  logic        rx_valid_in;
  logic [7:0]  rx_data_in;
  logic        tx_valid_out;
  logic        tx_ready_in;
  logic [7:0]  tx_data_out;
  logic [31:0] address_out;
  logic        read_out;
  logic        write_out;
  logic [3:0]  write_mask_out;
  logic [31:0] write_value_out;
  logic [31:0] read_value_in;
  logic        ready_in;

  int n_checks = 0;
  int n_errors = 0;
  int rd_cycles = 0;
  int wr_cycles = 0;
  logic [7:0] exp_q[$];

  debug_bridge #(.TIMEOUT_CYCLES(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .rx_valid_in     (rx_valid_in),
    .rx_data_in      (rx_data_in),
    .tx_valid_out    (tx_valid_out),
    .tx_ready_in     (tx_ready_in),
    .tx_data_out     (tx_data_out),
    .address_out     (address_out),
    .read_out        (read_out),
    .write_out       (write_out),
    .write_mask_out  (write_mask_out),
    .write_value_out (write_value_out),
    .read_value_in   (read_value_in),
    .ready_in        (ready_in)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard: every accepted response byte must be the next expected one.
  always @(negedge clk) begin
    if (!reset && tx_valid_out && tx_ready_in) begin
      if (exp_q.size() == 0) check_val("tx_unexpected_byte", {24'd0, tx_data_out}, 32'hFFFF_FFFF);
      else                   check_val("tx_byte", {24'd0, tx_data_out}, {24'd0, exp_q.pop_front()});
    end
  end

  // Bus monitor: request cycle counts and read/write exclusivity.
  always @(negedge clk) begin
    if (!reset) begin
      if (read_out)  rd_cycles++;
      if (write_out) wr_cycles++;
      if (read_out && write_out) check_val("rd_wr_both_high", 32'd1, 32'd0);
    end
  end

  // Driver tasks
  task automatic send_byte(input logic [7:0] b);
    rx_valid_in = 1'b1;
    rx_data_in  = b;
    @(posedge clk); #1;
    rx_valid_in = 1'b0;
    rx_data_in  = 8'd0;
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic [31:0] addr);
    send_byte(op);
    for (int i = 3; i >= 0; i--) send_byte(addr[8*i +: 8]);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) exp_q.push_back(w[8*i +: 8]);
  endtask

  task automatic wait_resp_done(input string tag, input int max_cycles);
    bit done = 1'b0;
    for (int i = 0; i < max_cycles && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !tx_valid_out) done = 1'b1;
    end
    check_val(tag, {31'd0, done}, 32'd1);
    @(posedge clk); #1;
  endtask

  int base;

  initial begin
    reset = 1'b1; rx_valid_in = 1'b0; rx_data_in = 8'd0; tx_ready_in = 1'b1;
    read_value_in = 32'd0; ready_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_tx_valid", {31'd0, tx_valid_out}, 32'd0);
    check_val("rst_tx_data", {24'd0, tx_data_out}, 32'd0);
    check_val("rst_read", {31'd0, read_out}, 32'd0);
    check_val("rst_write", {31'd0, write_out}, 32'd0);
    check_val("rst_mask", {28'd0, write_mask_out}, 32'd0);
    check_val("rst_addr", address_out, 32'd0);
    check_val("rst_wval", write_value_out, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Write, bus ready immediately: one write cycle, response 'K'.
    base = wr_cycles;
    ready_in = 1'b1;
    exp_q.push_back(8'h4B);
    send_cmd(8'h57, 32'h0001_0000);
    send_word(32'h0000_00A5);
    @(negedge clk);
    check_val("wr_write", {31'd0, write_out}, 32'd1);
    check_val("wr_read", {31'd0, read_out}, 32'd0);
    check_val("wr_addr", address_out, 32'h0001_0000);
    check_val("wr_value", write_value_out, 32'h0000_00A5);
    check_val("wr_mask", {28'd0, write_mask_out}, 32'hF);
    @(posedge clk); #1;
    ready_in = 1'b0;
    @(negedge clk);
    check_val("wr_tx_valid_next", {31'd0, tx_valid_out}, 32'd1);
    wait_resp_done("wr_resp_done", 20);
    check_val("wr_cycles", wr_cycles - base, 32'd1);

    // Read with a 5-cycle stall: read_out high for 6 cycles, address stable.
    base = rd_cycles;
    push_word(32'h1234_5678);
    send_cmd(8'h52, 32'h0003_0004);
    repeat (5) begin
      @(negedge clk);
      check_val("rd_stall_read", {31'd0, read_out}, 32'd1);
      check_val("rd_stall_mask", {28'd0, write_mask_out}, 32'd0);
      check_val("rd_stall_addr", address_out, 32'h0003_0004);
      @(posedge clk); #1;
    end
    ready_in = 1'b1;
    read_value_in = 32'h1234_5678;
    @(posedge clk); #1;
    ready_in = 1'b0;
    read_value_in = 32'd0;
    wait_resp_done("rd_resp_done", 20);
    check_val("rd_cycles", rd_cycles - base, 32'd6);

    // Tx backpressure: first byte held for 10 cycles, then all four delivered.
    push_word(32'h1234_5678);
    tx_ready_in = 1'b0;
    ready_in = 1'b1;
    read_value_in = 32'h1234_5678;
    send_cmd(8'h52, 32'h0000_0040);
    @(posedge clk); #1;
    ready_in = 1'b0;
    read_value_in = 32'd0;
    repeat (10) begin
      @(negedge clk);
      check_val("bp_valid", {31'd0, tx_valid_out}, 32'd1);
      check_val("bp_hold", {24'd0, tx_data_out}, 32'h12);
      @(posedge clk); #1;
    end
    tx_ready_in = 1'b1;
    wait_resp_done("bp_resp_done", 20);

    // Invalid command byte -> '?' on the next cycle.
    exp_q.push_back(8'h3F);
    send_byte(8'h00);
    @(negedge clk);
    check_val("inv_tx_valid", {31'd0, tx_valid_out}, 32'd1);
    wait_resp_done("inv_resp_done", 10);

    // Bytes arriving during BUS are dropped; write result unchanged.
    base = wr_cycles;
    exp_q.push_back(8'h4B);
    send_cmd(8'h57, 32'h0000_0010);
    send_word(32'hDEAD_BEEF);
    send_byte(8'h52);
    send_byte(8'h00);
    ready_in = 1'b1;
    @(negedge clk);
    check_val("drop_addr", address_out, 32'h0000_0010);
    check_val("drop_value", write_value_out, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    ready_in = 1'b0;
    wait_resp_done("drop_resp_done", 20);
    check_val("drop_wr_cycles", wr_cycles - base, 32'd3);

    // Reset after two address bytes discards the command.
    send_byte(8'h52);
    send_byte(8'h00);
    send_byte(8'h01);
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_val("mid_rst_addr", address_out, 32'd0);
    check_val("mid_rst_read", {31'd0, read_out}, 32'd0);
    check_val("mid_rst_tx_valid", {31'd0, tx_valid_out}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    push_word(32'hCAFE_F00D);
    ready_in = 1'b1;
    read_value_in = 32'hCAFE_F00D;
    send_cmd(8'h52, 32'h0000_0008);
    @(negedge clk);
    check_val("post_rst_read", {31'd0, read_out}, 32'd1);
    check_val("post_rst_addr", address_out, 32'h0000_0008);
    @(posedge clk); #1;
    ready_in = 1'b0;
    read_value_in = 32'd0;
    wait_resp_done("post_rst_resp_done", 20);

`ifdef DEBUG_BRIDGE_TIMEOUT_EN
    // Read with no ready_in: request lasts 8 cycles, response is 'E'.
    base = rd_cycles;
    exp_q.push_back(8'h45);
    send_cmd(8'h52, 32'h0000_0100);
    wait_resp_done("tmo_resp_done", 40);
    check_val("tmo_rd_cycles", rd_cycles - base, 32'd8);
`endif

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) check_val("leftover_expected", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
